// File: rtl/paillier_ctrl_regs.sv
// AXI4-Lite control/status register block for the Paillier accelerator core.
// Optional build macro PAILLIER_CTRL_IRQ_EN adds the IRQ_EN register (0x1C) and the irq output.
module paillier_ctrl_regs #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    M_AXI_ACLK,
    input  logic                    M_AXI_ARESETN,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    output logic [1:0]              core_mode,
    output logic [15:0]             core_block_count,
    output logic [63:0]             core_rd_base,
    output logic [63:0]             core_wr_base,
    output logic                    core_start,
`ifdef PAILLIER_CTRL_IRQ_EN
    output logic                    irq,
`endif
    input  logic                    core_busy,
    input  logic                    core_done
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam logic [IW-1:0] A_CTRL   = IW'(0);
    localparam logic [IW-1:0] A_STATUS = IW'(1);
    localparam logic [IW-1:0] A_COUNT  = IW'(2);
    localparam logic [IW-1:0] A_RDLO   = IW'(3);
    localparam logic [IW-1:0] A_RDHI   = IW'(4);
    localparam logic [IW-1:0] A_WRLO   = IW'(5);
    localparam logic [IW-1:0] A_WRHI   = IW'(6);
`ifdef PAILLIER_CTRL_IRQ_EN
    localparam logic [IW-1:0] A_IRQEN  = IW'(7);
    logic irq_en, irq_en_nxt;
`endif

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic          armed, wr_go, rd_go, wr_ok, rd_ok, start_req, done, done_nxt, start_err;
    logic [IW-1:0] aw_idx, ar_idx;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic          unused_addr_lsbs;

    assign aw_idx           = S_AXI_AWADDR[ADDR_WIDTH-1:2];
    assign ar_idx           = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
    assign start_req        = S_AXI_WSTRB[0] & S_AXI_WDATA[0];

    // Holds off all handshakes until the first clock edge after reset release.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESETN) begin
        if (M_AXI_ARESETN) armed <= 1'b0;
        else               armed <= 1'b1;
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESETN) begin
        if (M_AXI_ARESETN) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    always_comb begin
        wr_next = wr_state;
        wr_go   = 1'b0;
        case (wr_state)
            WR_IDLE: if (armed && S_AXI_AWVALID && S_AXI_WVALID) begin
                wr_go   = 1'b1;
                wr_next = WR_RESP;
            end
            WR_RESP: if (S_AXI_BREADY) wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        rd_go   = 1'b0;
        case (rd_state)
            RD_IDLE: if (armed && S_AXI_ARVALID) begin
                rd_go   = 1'b1;
                rd_next = RD_DATA;
            end
            RD_DATA: if (S_AXI_RREADY) rd_next = RD_IDLE;
        endcase
    end

    assign S_AXI_AWREADY = wr_go;
    assign S_AXI_WREADY  = wr_go;
    assign S_AXI_BVALID  = (wr_state == WR_RESP);
    assign S_AXI_ARREADY = rd_go;
    assign S_AXI_RVALID  = (rd_state == RD_DATA);

    // A START while busy is reported through START_ERR, so it still answers OKAY.
    always_comb begin
        wr_ok = 1'b0;
        case (aw_idx)
            A_CTRL:   wr_ok = !core_busy || start_req;
            A_STATUS: wr_ok = 1'b1;
            A_COUNT, A_RDLO, A_RDHI, A_WRLO, A_WRHI: wr_ok = !core_busy;
`ifdef PAILLIER_CTRL_IRQ_EN
            A_IRQEN:  wr_ok = 1'b1;
`endif
            default:  wr_ok = 1'b0;
        endcase
    end

    // core_done beats a simultaneous write-1-to-clear.
    assign done_nxt = core_done | (done & !(wr_go && aw_idx == A_STATUS &&
                                            S_AXI_WSTRB[0] && S_AXI_WDATA[1]));
`ifdef PAILLIER_CTRL_IRQ_EN
    assign irq_en_nxt = (wr_go && aw_idx == A_IRQEN && S_AXI_WSTRB[0]) ? S_AXI_WDATA[0] : irq_en;
`endif

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESETN) begin
        if (M_AXI_ARESETN) begin
            core_mode        <= '0;
            core_block_count <= '0;
            core_rd_base     <= '0;
            core_wr_base     <= '0;
            core_start       <= 1'b0;
            done             <= 1'b0;
            start_err        <= 1'b0;
            S_AXI_BRESP      <= 2'b00;
`ifdef PAILLIER_CTRL_IRQ_EN
            irq_en           <= 1'b0;
            irq              <= 1'b0;
`endif
        end else begin
            core_start <= 1'b0;
            done       <= done_nxt;
`ifdef PAILLIER_CTRL_IRQ_EN
            irq_en     <= irq_en_nxt;
            irq        <= done_nxt & irq_en_nxt;
`endif
            if (wr_go) begin
                S_AXI_BRESP <= wr_ok ? 2'b00 : 2'b10;
                case (aw_idx)
                    A_CTRL: begin
                        if (!core_busy) begin
                            if (S_AXI_WSTRB[0]) core_mode <= S_AXI_WDATA[2:1];
                            core_start <= start_req;
                        end else if (start_req) begin
                            start_err <= 1'b1;
                        end
                    end
                    A_STATUS: if (S_AXI_WSTRB[0] && S_AXI_WDATA[2]) start_err <= 1'b0;
                    A_COUNT: if (!core_busy)
                        for (int b = 0; b < 2; b++)
                            if (S_AXI_WSTRB[b]) core_block_count[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                    A_RDLO, A_RDHI: if (!core_busy)
                        for (int b = 0; b < 4; b++)
                            if (S_AXI_WSTRB[b])
                                core_rd_base[(aw_idx == A_RDHI ? 32 : 0) + 8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                    A_WRLO, A_WRHI: if (!core_busy)
                        for (int b = 0; b < 4; b++)
                            if (S_AXI_WSTRB[b])
                                core_wr_base[(aw_idx == A_WRHI ? 32 : 0) + 8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        rd_ok  = 1'b1;
        case (ar_idx)
            A_CTRL:   rd_mux = {29'd0, core_mode, 1'b0};
            A_STATUS: rd_mux = {29'd0, start_err, done, core_busy};
            A_COUNT:  rd_mux = {16'd0, core_block_count};
            A_RDLO:   rd_mux = core_rd_base[31:0];
            A_RDHI:   rd_mux = core_rd_base[63:32];
            A_WRLO:   rd_mux = core_wr_base[31:0];
            A_WRHI:   rd_mux = core_wr_base[63:32];
`ifdef PAILLIER_CTRL_IRQ_EN
            A_IRQEN:  rd_mux = {31'd0, irq_en};
`endif
            default:  rd_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESETN) begin
        if (M_AXI_ARESETN) begin
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= 2'b00;
        end else if (rd_go) begin
            S_AXI_RDATA <= rd_mux;
            S_AXI_RRESP <= rd_ok ? 2'b00 : 2'b10;
        end
    end
endmodule

// File: tb/tb_paillier_ctrl_regs.sv
// Scoreboard bench for paillier_ctrl_regs: directed scenarios plus randomized traffic vs a register-map model.
`timescale 1ns/1ps
module tb_paillier_ctrl_regs;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [1:0]  core_mode;
    logic [15:0] core_block_count;
    logic [63:0] core_rd_base, core_wr_base;
    logic        core_start;
    logic        core_busy = 1'b0, core_done = 1'b0;
`ifdef PAILLIER_CTRL_IRQ_EN
    logic        irq;
`endif
    logic        rnd_rdy = 1'b0;
    int          checks = 0, failures = 0;

    // reference model state: the register map as seen by software
    logic [1:0]  m_mode;
    logic [15:0] m_cnt;
    logic [63:0] m_rd, m_wr;
    logic        m_done, m_serr, m_irqen;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    logic [17:0] sq[$];

    always #5 clk = ~clk;

    paillier_ctrl_regs #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .core_mode(core_mode), .core_block_count(core_block_count),
        .core_rd_base(core_rd_base), .core_wr_base(core_wr_base), .core_start(core_start),
`ifdef PAILLIER_CTRL_IRQ_EN
        .irq(irq),
`endif
        .core_busy(core_busy), .core_done(core_done)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic m_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, input logic dn);
        logic [1:0]  resp;
        logic        st;
        logic [31:0] t;
        resp = 2'b00;
        st   = s[0] & d[0];
        case (a)
            6'h00: if (core_busy) begin
                       if (st) m_serr = 1'b1; else resp = 2'b10;
                   end else begin
                       if (s[0]) m_mode = d[2:1];
                       if (st) sq.push_back({m_mode, m_cnt});
                   end
            6'h04: begin
                       if (s[0] && d[1]) m_done = 1'b0;
                       if (s[0] && d[2]) m_serr = 1'b0;
                   end
            6'h08: if (core_busy) resp = 2'b10;
                   else begin t = merge({16'd0, m_cnt}, d, s); m_cnt = t[15:0]; end
            6'h0C: if (core_busy) resp = 2'b10; else m_rd[31:0]  = merge(m_rd[31:0], d, s);
            6'h10: if (core_busy) resp = 2'b10; else m_rd[63:32] = merge(m_rd[63:32], d, s);
            6'h14: if (core_busy) resp = 2'b10; else m_wr[31:0]  = merge(m_wr[31:0], d, s);
            6'h18: if (core_busy) resp = 2'b10; else m_wr[63:32] = merge(m_wr[63:32], d, s);
`ifdef PAILLIER_CTRL_IRQ_EN
            6'h1C: if (s[0]) m_irqen = d[0];
`endif
            default: resp = 2'b10;
        endcase
        if (dn) m_done = 1'b1;
        bq.push_back(resp);
    endtask

    function automatic logic [33:0] m_read(input logic [5:0] a);
        case (a)
            6'h00: return {2'b00, 29'd0, m_mode, 1'b0};
            6'h04: return {2'b00, 29'd0, m_serr, m_done, core_busy};
            6'h08: return {2'b00, 16'd0, m_cnt};
            6'h0C: return {2'b00, m_rd[31:0]};
            6'h10: return {2'b00, m_rd[63:32]};
            6'h14: return {2'b00, m_wr[31:0]};
            6'h18: return {2'b00, m_wr[63:32]};
`ifdef PAILLIER_CTRL_IRQ_EN
            6'h1C: return {2'b00, 31'd0, m_irqen};
`endif
            default: return {2'b10, 32'd0};
        endcase
    endfunction

    // response readiness with random back-pressure
    always @(posedge clk) begin
        #1;
        bready = rnd_rdy && ($urandom_range(0, 3) != 0);
        rready = rnd_rdy && ($urandom_range(0, 3) != 0);
    end

    // monitor: pops expectations whenever the DUT completes a response or pulses start
    always @(negedge clk) begin
        if (!rst) begin
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL bresp_unexpected actual=%0h required=none", bresp);
                end else chk("bresp", bresp, bq.pop_front());
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rdata_unexpected actual=%0h required=none", rdata);
                end else chk("rresp_rdata", {rresp, rdata}, rq.pop_front());
            end
            if (core_start) begin
                if (sq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL core_start_unexpected actual=1 required=0");
                end else chk("start_mode_count", {core_mode, core_block_count}, sq.pop_front());
            end
        end
    end

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, input logic dn = 1'b0);
        int n;
        n = 0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        while (!(awready && wready) && n < 100) begin @(negedge clk); #1; n++; end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL wr_timeout addr=%0h actual=no_ready required=ready", a);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        core_done = dn;
        m_write(a, d, s, dn);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; core_done = 1'b0;
        chk("core_mode", core_mode, m_mode);
        chk("core_block_count", core_block_count, m_cnt);
        chk("core_rd_base", core_rd_base, m_rd);
        chk("core_wr_base", core_wr_base, m_wr);
`ifdef PAILLIER_CTRL_IRQ_EN
        chk("irq", irq, m_done & m_irqen);
`endif
    endtask

    task automatic rd(input logic [5:0] a);
        int n;
        n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        #1;
        while (!arready && n < 100) begin @(negedge clk); #1; n++; end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL rd_timeout addr=%0h actual=no_ready required=ready", a);
            arvalid = 1'b0;
            return;
        end
        rq.push_back(m_read(a));
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk); core_done = 1'b1; m_done = 1'b1;
        @(negedge clk); core_done = 1'b0;
`ifdef PAILLIER_CTRL_IRQ_EN
        chk("irq_after_done", irq, m_irqen);
`endif
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((bq.size() != 0 || rq.size() != 0 || sq.size() != 0) && n < 200) begin
            @(negedge clk); n++;
        end
        chk("bq_left", bq.size(), 0);
        chk("rq_left", rq.size(), 0);
        chk("sq_left", sq.size(), 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1; core_done = 1'b0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_resp", {bresp, rresp}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_core", {core_start, core_mode, core_block_count}, 0);
        chk("rst_bases", core_rd_base | core_wr_base, 0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bq.delete(); rq.delete(); sq.delete();
        m_mode = '0; m_cnt = '0; m_rd = '0; m_wr = '0;
        m_done = 1'b0; m_serr = 1'b0; m_irqen = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        awaddr = 6'h08; wdata = 32'h1; wstrb = 4'hF; araddr = 6'h00;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        #1;
        chk("early_awready", awready, 0);
        chk("early_arready", arready, 0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        apply_reset();
        rnd_rdy = 1'b1;

        wr(6'h0C, 32'h1000_0000, 4'hF);
        wr(6'h10, 32'h0000_0001, 4'hF);
        chk("rd_base_value", core_rd_base, 64'h1_1000_0000);
        rd(6'h0C);
        rd(6'h10);

        wr(6'h08, 32'h0000_0005, 4'hF);
        wr(6'h00, 32'h0000_0001, 4'hF);
        rd(6'h08);

        @(negedge clk); core_busy = 1'b1;
        wr(6'h00, 32'h0000_0007, 4'hF);
        rd(6'h04);
        wr(6'h08, 32'h0000_0009, 4'hF);
        rd(6'h08);
        @(negedge clk); core_busy = 1'b0;

        wr(6'h04, 32'h0000_0002, 4'hF, 1'b1);
        rd(6'h04);
        wr(6'h04, 32'h0000_0006, 4'hF);
        rd(6'h04);

        wr(6'h18, 32'hDEAD_BEEF, 4'b0101);
        rd(6'h18);
        rd(6'h3C);
        rd(6'h1C);
        wr(6'h3C, 32'hFFFF_FFFF, 4'hF);

`ifdef PAILLIER_CTRL_IRQ_EN
        wr(6'h1C, 32'h1, 4'hF);
        pulse_done();
        wr(6'h04, 32'h2, 4'hF);
`endif

        fork
            wr(6'h14, 32'hA5A5_0000, 4'hF);
            rd(6'h08);
        join

        for (int i = 0; i < 300; i++) begin
            int          op;
            logic [5:0]  a;
            logic [3:0]  s;
            op = $urandom_range(0, 9);
            a  = {4'($urandom_range(0, 15)), 2'b00};
            s  = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            if (op == 0) begin
                @(negedge clk); core_busy = ~core_busy;
            end else if (op == 1) pulse_done();
            else if (op < 6) rd(a);
            else wr(a, $urandom, s);
        end
        @(negedge clk); core_busy = 1'b0;
        drain();

        rnd_rdy = 1'b0;
        repeat (2) @(negedge clk);
        wr(6'h08, 32'h0000_0003, 4'hF);
        chk("bvalid_before_reset", bvalid, 1);
        rst = 1'b1;
        #1;
        chk("bvalid_async_reset", bvalid, 0);
        chk("count_async_reset", core_block_count, 0);
        apply_reset();
        rnd_rdy = 1'b1;
        wr(6'h08, 32'h0000_0011, 4'h1);
        rd(6'h08);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/paillier_ctrl_regs.md
PAILLIER_CTRL_REGS -- requirements
Module: paillier_ctrl_regs

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 6, the AXI4-Lite byte-address width (register window 0x00-0x3F).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the AXI4-Lite data width; only 32 is supported.
REQ-003 The block SHALL have M_AXI_ACLK, input, 1, the clock for all logic.
REQ-004 The block SHALL have M_AXI_ARESETN, input, 1, the reset, which is asynchronous and active-high.
REQ-005 The block SHALL have S_AXI_AWADDR/AWVALID/AWREADY, in/in/out, ADDR_WIDTH/1/1, the write-address channel.
REQ-006 The block SHALL have S_AXI_WDATA/WSTRB/WVALID/WREADY, in/in/in/out, 32/4/1/1, the write-data channel.
REQ-007 The block SHALL have S_AXI_BRESP/BVALID/BREADY, out/out/in, 2/1/1, the write-response channel.
REQ-008 The block SHALL have S_AXI_ARADDR/ARVALID/ARREADY, in/in/out, ADDR_WIDTH/1/1, the read-address channel.
REQ-009 The block SHALL have S_AXI_RDATA/RRESP/RVALID/RREADY, out/out/out/in, 32/2/1/1, the read-data channel.
REQ-010 The block SHALL have core_mode, output, 2, the Paillier operation: 00 encryption, 01 decryption, 10 homomorphic add, 11 scalar multiply.
REQ-011 The block SHALL have core_block_count, output, 16, the number of operand blocks to process.
REQ-012 The block SHALL have core_rd_base and core_wr_base, outputs, 64 each, the AXI-Full operand and result base addresses.
REQ-013 The block SHALL have core_start, output, 1, a one-cycle pulse that launches the core.
REQ-014 The block SHALL have core_busy (input, 1, level) and core_done (input, 1, one-cycle pulse) from the core.

Function
REQ-015 The register map SHALL be: 0x00 CTRL (bit0 START write-1 self-clearing, bits[2:1] MODE); 0x04 STATUS (bit0 BUSY read-only, bit1 DONE sticky write-1-to-clear, bit2 START_ERR sticky write-1-to-clear); 0x08 BLOCK_COUNT[15:0]; 0x0C/0x10 RD_BASE lo/hi; 0x14/0x18 WR_BASE lo/hi.
REQ-016 The write FSM SHALL have states IDLE -> RESP; it leaves IDLE only when AWVALID and WVALID are both high and BVALID is low.
REQ-017 In that cycle the block SHALL pulse AWREADY and WREADY together and commit the write with per-byte WSTRB.
REQ-018 BVALID SHALL assert the next cycle and hold until BREADY; the FSM then returns to IDLE; back-to-back writes SHALL sustain one write per 2 cycles.
REQ-019 Read: when ARVALID is high and RVALID is low, the block SHALL pulse ARREADY, and RVALID with RDATA SHALL follow 1 cycle later, held stable until RREADY.
REQ-020 Unmapped addresses SHALL read 0 and ignore writes, with RESP=SLVERR (2'b10); mapped accesses SHALL return OKAY.
REQ-021 Writing START=1 while core_busy=0 SHALL pulse core_start one cycle after the write commits, with MODE latched in the same write.
REQ-022 Writing START=1 while core_busy=1 SHALL drop the start, set START_ERR and respond OKAY.
REQ-023 Writes to MODE, BLOCK_COUNT, RD_BASE or WR_BASE while core_busy=1 SHALL be ignored and respond SLVERR, so the outputs stay frozen during an operation.
REQ-024 core_done SHALL set DONE; if core_done and a write-1-to-clear of DONE coincide, set SHALL win.
REQ-025 A read SHALL be accepted in the same cycle as a write, with independent FSMs.

Reset
REQ-026 While M_AXI_ARESETN is high: all READY/VALID outputs 0, RESP 0, RDATA 0, all registers 0, core_start 0, FSMs IDLE; an in-flight response is abandoned.
REQ-027 After deassertion, the first handshake SHALL be accepted no earlier than the second rising edge.

Configuration
REQ-028 With PAILLIER_CTRL_IRQ_EN defined, the block SHALL add output irq (1 bit) and register 0x1C IRQ_EN (bit0); irq = DONE & IRQ_EN, registered, reset 0.
REQ-029 Without PAILLIER_CTRL_IRQ_EN, the irq port and 0x1C SHALL NOT exist, and 0x1C SHALL behave as unmapped (read 0, SLVERR).

Verification
REQ-030 Write 0x0C=0x1000_0000, 0x10=0x1 -> core_rd_base=64'h1_1000_0000, BRESP=00; read back returns the same values.
REQ-031 Write 0x08=0x0005, then CTRL=0x1 -> core_start single pulse, core_mode=00, core_block_count=5.
REQ-032 With core_busy=1, write CTRL=0x7 -> no core_start, STATUS reads 0x5; write 0x08=9 -> BRESP=10, count stays 5.
REQ-033 Pulse core_done in the same cycle as a W1C of STATUS=0x2 -> STATUS bit1 reads 1.
REQ-034 Read 0x3C -> RDATA=0, RRESP=10; assert reset while BVALID=1 -> BVALID=0 on the same cycle.
REQ-035 With PAILLIER_CTRL_IRQ_EN defined, write IRQ_EN=1 and pulse core_done -> irq=1 next cycle; W1C DONE -> irq=0.
